// File: rtl/sliding_window_buffer_if.sv
// rtl/sliding_window_buffer_if.sv - pixel beat stream in, per-lane window stream out
interface sliding_window_buffer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNAL_SIZE = 5,
  parameter int LANES       = 2
);
  logic                                                in_valid;
  logic [LANES*DATA_WIDTH-1:0]                         in_data;
  logic [LANES*KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH-1:0] win_data;
  logic [LANES-1:0]                                    win_valid;
  logic                                                frame_end;

  modport master (output in_valid, in_data, input win_data, win_valid, frame_end);
  modport slave  (input in_valid, in_data, output win_data, win_valid, frame_end);
endinterface

// File: rtl/sliding_window_buffer.sv
// rtl/sliding_window_buffer.sv - line buffer exposing LANES adjacent KxK windows per beat
module sliding_window_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 32,
  parameter int KERNAL_SIZE = 5,
  parameter int LANES       = 2,
  parameter int STRIDE      = 1,
  parameter int BUF_SIZE    = (KERNAL_SIZE-1)*IFM_SIZE+KERNAL_SIZE+LANES-1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_restart,
  sliding_window_buffer_if.slave stream
);
  localparam int K     = KERNAL_SIZE;
  localparam int CW    = $clog2(IFM_SIZE+LANES+1);
  localparam int SW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int SW1   = SW + 1;
  localparam int KOFF  = (K-1) % STRIDE;
  localparam int LSTEP = LANES % STRIDE;

  logic [DATA_WIDTH-1:0] buf_q [BUF_SIZE];
  logic [CW-1:0]         col_q, row_q;
  logic [SW-1:0]         cph_q, rph_q;
  logic [LANES-1:0]      win_valid_q;
  logic                  frame_end_q;

  logic [CW-1:0]    col_b, row_b;
  logic [SW-1:0]    cph_b, rph_b, cph_adv, rph_inc;
  logic [SW1-1:0]   cph_sum, cph_wrap;
  logic             row_last, col_last, row_wrap;
  logic [LANES-1:0] lane_valid;
  logic             accept;

  assign accept = stream.in_valid;

  // A restart zeroes the position before the simultaneous beat is classified
  always_comb begin
    col_b = col_q;
    row_b = row_q;
    cph_b = cph_q;
    rph_b = rph_q;
    if (frame_restart) begin
      col_b = '0;
      row_b = '0;
      cph_b = '0;
      rph_b = '0;
    end
  end

  assign row_last = (row_b == CW'(IFM_SIZE-1));
  assign col_last = (col_b == CW'(IFM_SIZE-LANES));
  assign row_wrap = ((col_b + CW'(LANES)) == CW'(IFM_SIZE));

  // Phases hold position mod STRIDE, so a stride hit is a phase compare
  assign cph_sum  = {1'b0, cph_b} + SW1'(LSTEP);
  assign cph_wrap = cph_sum - SW1'(STRIDE);
  assign cph_adv  = (cph_sum >= SW1'(STRIDE)) ? cph_wrap[SW-1:0] : cph_sum[SW-1:0];
  assign rph_inc  = (rph_b == SW'(STRIDE-1)) ? '0 : rph_b + SW'(1);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    localparam int JS = j % STRIDE;
    logic [SW1-1:0] sum, wrap, ph;
    assign sum  = {1'b0, cph_b} + SW1'(JS);
    assign wrap = sum - SW1'(STRIDE);
    assign ph   = (sum >= SW1'(STRIDE)) ? wrap : sum;
    assign lane_valid[j] = (row_b >= CW'(K-1)) && ((col_b + CW'(j)) >= CW'(K-1)) &&
                           (rph_b == SW'(KOFF)) && (ph == SW1'(KOFF));

    for (genvar kr = 0; kr < K; kr++) begin : g_row
      for (genvar kc = 0; kc < K; kc++) begin : g_col
        assign stream.win_data[((j*K*K)+kr*K+kc)*DATA_WIDTH +: DATA_WIDTH] =
          buf_q[(LANES-1-j) + (K-1-kr)*IFM_SIZE + (K-1-kc)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BUF_SIZE; i++) buf_q[i] <= '0;
      col_q       <= '0;
      row_q       <= '0;
      cph_q       <= '0;
      rph_q       <= '0;
      win_valid_q <= '0;
      frame_end_q <= 1'b0;
    end else begin
      win_valid_q <= '0;
      frame_end_q <= 1'b0;
      col_q       <= col_b;
      row_q       <= row_b;
      cph_q       <= cph_b;
      rph_q       <= rph_b;
      if (accept) begin
        for (int i = LANES; i < BUF_SIZE; i++) buf_q[i] <= buf_q[i-LANES];
        for (int j = 0; j < LANES; j++)
          buf_q[LANES-1-j] <= stream.in_data[j*DATA_WIDTH +: DATA_WIDTH];
        win_valid_q <= lane_valid;
        frame_end_q <= row_last && col_last;
        if (row_wrap) begin
          col_q <= '0;
          cph_q <= '0;
          row_q <= row_last ? '0 : row_b + CW'(1);
          rph_q <= row_last ? '0 : rph_inc;
        end else begin
          col_q <= col_b + CW'(LANES);
          cph_q <= cph_adv;
        end
      end
    end
  end

  assign stream.win_valid = win_valid_q;
  assign stream.frame_end = frame_end_q;
endmodule
